// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for a 5-stage in-order core.
//
// Resolves three kinds of hazard seen from the ID/EX boundary:
//   * control hazards: a taken branch/jump in EX flushes IF/ID and ID/EX;
//   * load-use hazards: a load in EX whose destination feeds the instruction
//     in ID stalls the front end for one cycle and inserts a bubble;
//   * multi-cycle units: a MUL/DIV or accelerator op in EX freezes the front
//     of the pipeline until its done strobe arrives, with a timeout watchdog.
//
// Ports
//   CLK              in   clock, all state updates on the rising edge
//   RST              in   synchronous active-low reset
//   id_rs1, id_rs2   in   [4:0] source registers of the instruction in ID
//   ex_rd            in   [4:0] destination register of the instruction in EX
//   ex_mem_read      in   EX instruction is a load
//   ex_branch_taken  in   EX resolved a taken branch/jump
//   md_start/md_done in   MUL/DIV op in EX / its result is valid
//   acc_req/acc_done in   accelerator op in EX / its result is valid
//   stall_pc, stall_ifid, stall_idex  out  hold the corresponding register
//   flush_ifid, flush_idex            out  zero the corresponding register
//   hz_state         out  [1:0] 00 IDLE, 01 MD_WAIT, 10 ACC_WAIT
//   wait_cnt         out  [7:0] cycles spent in the current wait state
//   timeout_err      out  sticky: a wait state ran out of time
module hazard_ctrl #(
  parameter int MD_TIMEOUT  = 64,   // 2..255
  parameter int ACC_TIMEOUT = 255   // 2..255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       md_start,
  input  logic       md_done,
  input  logic       acc_req,
  input  logic       acc_done,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       stall_idex,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic [1:0] hz_state,
  output logic [7:0] wait_cnt,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    MD_WAIT  = 2'b01,
    ACC_WAIT = 2'b10
  } state_t;

  // Last count value allowed before the watchdog fires.
  localparam logic [7:0] MD_LAST  = 8'(MD_TIMEOUT - 1);
  localparam logic [7:0] ACC_LAST = 8'(ACC_TIMEOUT - 1);

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       err_reg, err_next;
  logic       load_use;

  // x0 is hard-wired zero, so a load "to" x0 never produces a real dependency.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    stall_idex = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;

    case (state_reg)
      IDLE: begin
        cnt_next = 8'd0;
        if (ex_branch_taken) begin
          // Redirect wins: the younger instructions are wrong-path anyway.
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end else if (md_start) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          stall_idex = 1'b1;
          state_next = MD_WAIT;
        end else if (acc_req) begin
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          stall_idex = 1'b1;
          state_next = ACC_WAIT;
        end else if (load_use) begin
          // Hold the consumer in ID and send a bubble into EX.
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
        end
      end

      MD_WAIT: begin
        stall_pc   = ~md_done;
        stall_ifid = ~md_done;
        stall_idex = ~md_done;
        if (md_done) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else if (cnt_reg == MD_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      ACC_WAIT: begin
        stall_pc   = ~acc_done;
        stall_ifid = ~acc_done;
        stall_idex = ~acc_done;
        if (acc_done) begin
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else if (cnt_reg == ACC_LAST) begin
          err_next   = 1'b1;
          state_next = IDLE;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 8'd0;
      end
    endcase

    // While reset is held the pipeline must not be frozen or flushed.
    if (!RST) begin
      stall_pc   = 1'b0;
      stall_ifid = 1'b0;
      stall_idex = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
    end
  end

  assign hz_state    = state_reg;
  assign wait_cnt    = cnt_reg;
  assign timeout_err = err_reg;

endmodule
